// File: rtl/operand_fetch_pkg.sv
// Shared constants and output-register state encoding for the LC-3 operand fetch stage.
// Optional build macro: BYPASS_EN (writeback-to-operand forwarding).
package operand_fetch_pkg;

    localparam int OF_DW   = 16;
    localparam int OF_NREG = 8;
    localparam int OF_AW   = 3;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/operand_fetch_if.sv
// Decode/register-file/writeback/execute signal bundle around the operand fetch stage.
// The stage uses the slave modport; the surrounding pipeline uses master.
interface operand_fetch_if
    import operand_fetch_pkg::*;
#(
    parameter int DW = OF_DW
);
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [OF_AW-1:0]    in_sr1;
    logic [OF_AW-1:0]    in_sr2;
    logic [OF_AW-1:0]    in_dr;
    logic                in_use1;
    logic                in_use2;
    logic                in_wr;
    logic [15:0]         in_npc;
    logic [15:0]         in_ir;
    logic [OF_AW-1:0]    rf_sr1;
    logic [OF_AW-1:0]    rf_sr2;
    logic [DW-1:0]       rf_d1;
    logic [DW-1:0]       rf_d2;
    logic                wb_valid;
    logic [OF_AW-1:0]    wb_dr;
    logic [DW-1:0]       wb_data;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_vsr1;
    logic [DW-1:0]       out_vsr2;
    logic [OF_AW-1:0]    out_dr;
    logic                out_wr;
    logic [15:0]         out_npc;
    logic [15:0]         out_ir;

    modport slave (
        input  flush, in_valid, in_sr1, in_sr2, in_dr, in_use1, in_use2, in_wr,
        input  in_npc, in_ir, rf_d1, rf_d2, wb_valid, wb_dr, wb_data, out_ready,
        output in_ready, rf_sr1, rf_sr2, out_valid, out_vsr1, out_vsr2,
        output out_dr, out_wr, out_npc, out_ir
    );

    modport master (
        output flush, in_valid, in_sr1, in_sr2, in_dr, in_use1, in_use2, in_wr,
        output in_npc, in_ir, rf_d1, rf_d2, wb_valid, wb_dr, wb_data, out_ready,
        input  in_ready, rf_sr1, rf_sr2, out_valid, out_vsr1, out_vsr2,
        input  out_dr, out_wr, out_npc, out_ir
    );

endinterface

// File: rtl/operand_scoreboard.sv
// Per-register in-flight write tracking with RAW/WAW hazard lookup.
// With BYPASS_EN a retiring write satisfies a hazard in its own cycle.
module operand_scoreboard
    import operand_fetch_pkg::*;
#(
    parameter int NREG = OF_NREG
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [OF_AW-1:0] sr1,
    input  logic [OF_AW-1:0] sr2,
    input  logic [OF_AW-1:0] dr,
    input  logic             use1,
    input  logic             use2,
    input  logic             wr,
    input  logic             wb_valid,
    input  logic [OF_AW-1:0] wb_dr,
    input  logic             set_en,
    input  logic             kill_en,
    input  logic [OF_AW-1:0] kill_dr,
    output logic             hit1,
    output logic             hit2,
    output logic             hazard,
    output logic [NREG-1:0]  pend
);

    logic            waw_free;
    logic            raw;
    logic            waw;
    logic [NREG-1:0] pend_next;

    always_comb begin
`ifdef BYPASS_EN
        hit1     = wb_valid && (wb_dr == sr1) && pend[sr1];
        hit2     = wb_valid && (wb_dr == sr2) && pend[sr2];
        waw_free = wb_valid && (wb_dr == dr);
`else
        hit1     = 1'b0;
        hit2     = 1'b0;
        waw_free = 1'b0;
`endif
        raw    = (use1 && pend[sr1] && !hit1) || (use2 && pend[sr2] && !hit2);
        waw    = wr && pend[dr] && !waw_free;
        hazard = raw || waw;
    end

    // Clears (writeback, flushed entry) take effect before the accept-side set,
    // so a same-register clear and set leaves the bit pending.
    always_comb begin
        pend_next = pend;
        for (int unsigned i = 0; i < NREG; i++) begin
            if ((wb_valid && (wb_dr == OF_AW'(i))) || (kill_en && (kill_dr == OF_AW'(i))))
                pend_next[i] = 1'b0;
            if (set_en && (dr == OF_AW'(i)))
                pend_next[i] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pend <= '0;
        else
            pend <= pend_next;
    end

endmodule

// File: rtl/operand_fetch.sv
// LC-3 register-read stage: scoreboard-gated accept and a single output pipeline register.
// Optional build macro: BYPASS_EN (forward writeback data into operand capture).
module operand_fetch
    import operand_fetch_pkg::*;
#(
    parameter int DW   = OF_DW,
    parameter int NREG = OF_NREG
) (
    input  logic            clock,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    out_state_e       state;
    logic [DW-1:0]    vsr1_q;
    logic [DW-1:0]    vsr2_q;
    logic [OF_AW-1:0] dr_q;
    logic             wr_q;
    logic [15:0]      npc_q;
    logic [15:0]      ir_q;

    logic             hit1;
    logic             hit2;
    logic             hazard;
    logic             accept;
    logic             kill_en;
    logic [NREG-1:0]  pend;

    operand_scoreboard #(
        .NREG (NREG)
    ) u_sb (
        .clock    (clock),
        .reset    (reset),
        .sr1      (bus.in_sr1),
        .sr2      (bus.in_sr2),
        .dr       (bus.in_dr),
        .use1     (bus.in_use1),
        .use2     (bus.in_use2),
        .wr       (bus.in_wr),
        .wb_valid (bus.wb_valid),
        .wb_dr    (bus.wb_dr),
        .set_en   (accept && bus.in_wr),
        .kill_en  (kill_en),
        .kill_dr  (dr_q),
        .hit1     (hit1),
        .hit2     (hit2),
        .hazard   (hazard),
        .pend     (pend)
    );

    assign bus.in_ready = !hazard && !bus.flush && ((state == EMPTY) || bus.out_ready);
    assign accept       = bus.in_valid && bus.in_ready;
    assign kill_en      = bus.flush && (state == FULL) && wr_q;

    assign bus.rf_sr1 = bus.in_sr1;
    assign bus.rf_sr2 = bus.in_sr2;

    // accept already implies the register is free or draining this cycle,
    // so field capture is independent of the state transition.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            vsr1_q <= '0;
            vsr2_q <= '0;
            dr_q   <= '0;
            wr_q   <= 1'b0;
            npc_q  <= '0;
            ir_q   <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) state <= FULL;
                FULL: begin
                    if (bus.flush)
                        state <= EMPTY;
                    else if (bus.out_ready && !accept)
                        state <= EMPTY;
                end
                default: state <= EMPTY;
            endcase
            if (accept) begin
                vsr1_q <= hit1 ? bus.wb_data : bus.rf_d1;
                vsr2_q <= hit2 ? bus.wb_data : bus.rf_d2;
                dr_q   <= bus.in_dr;
                wr_q   <= bus.in_wr;
                npc_q  <= bus.in_npc;
                ir_q   <= bus.in_ir;
            end
        end
    end

    assign bus.out_valid = (state == FULL);
    assign bus.out_vsr1  = vsr1_q;
    assign bus.out_vsr2  = vsr2_q;
    assign bus.out_dr    = dr_q;
    assign bus.out_wr    = wr_q;
    assign bus.out_npc   = npc_q;
    assign bus.out_ir    = ir_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized bench for operand_fetch against a register-level reference model.
// Build with or without BYPASS_EN; expectations follow the macro.
module tb_operand_fetch;
    import operand_fetch_pkg::*;

`ifdef BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [15:0] v1;
        logic [15:0] v2;
        logic [2:0]  dr;
        logic        wr;
        logic [15:0] npc;
        logic [15:0] ir;
    } ent_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    operand_fetch_if #(.DW(16)) bus();

    operand_fetch #(.DW(16), .NREG(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] rf [8];
    assign bus.rf_d1 = rf[bus.rf_sr1];
    assign bus.rf_d2 = rf[bus.rf_sr2];

    bit          mpend [8];
    ent_t        m;
    int          compared   = 0;
    int          mismatched = 0;
    bit          last_acc;
    int          acc_count;
    int          out_count;
    bit          track_npc;
    logic [15:0] npcq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pend_vec();
        logic [7:0] v;
        for (int i = 0; i < 8; i++) v[i] = mpend[i];
        return v;
    endfunction

    function automatic bit fwd(input logic [2:0] s);
        return BYP && bus.wb_valid && (bus.wb_dr == s) && mpend[s];
    endfunction

    function automatic bit model_ready();
        bit stall;
        stall = (bus.in_use1 && mpend[bus.in_sr1] && !fwd(bus.in_sr1)) ||
                (bus.in_use2 && mpend[bus.in_sr2] && !fwd(bus.in_sr2)) ||
                (bus.in_wr && mpend[bus.in_dr] && !(BYP && bus.wb_valid && bus.wb_dr == bus.in_dr));
        return !stall && !bus.flush && (!m.valid || bus.out_ready);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mpend[i] = 1'b0;
        m = '0;
    endtask

    task automatic set_instr(input bit v, input logic [2:0] s1, input bit u1, input logic [2:0] s2,
                             input bit u2, input logic [2:0] d, input bit w,
                             input logic [15:0] npc, input logic [15:0] ir);
        bus.in_valid = v;  bus.in_sr1 = s1; bus.in_use1 = u1; bus.in_sr2 = s2;
        bus.in_use2  = u2; bus.in_dr  = d;  bus.in_wr   = w;  bus.in_npc = npc; bus.in_ir = ir;
    endtask

    task automatic set_wb(input bit v, input logic [2:0] d, input logic [15:0] data);
        bus.wb_valid = v; bus.wb_dr = d; bus.wb_data = data;
    endtask

    // One clock: check combinational outputs before the edge, advance the model, check registers after.
    task automatic tick();
        bit          rdy, acc;
        logic [15:0] d1, d2;
        #1;
        rdy = model_ready();
        chk("in_ready", bus.in_ready, rdy);
        chk("rf_sr1", bus.rf_sr1, bus.in_sr1);
        chk("rf_sr2", bus.rf_sr2, bus.in_sr2);
        if (m.valid && bus.out_ready && !bus.flush) begin
            out_count++;
            if (track_npc && npcq.size() > 0) chk("npc_order", bus.out_npc, npcq.pop_front());
        end
        acc = bus.in_valid && rdy;
        d1  = fwd(bus.in_sr1) ? bus.wb_data : rf[bus.in_sr1];
        d2  = fwd(bus.in_sr2) ? bus.wb_data : rf[bus.in_sr2];
        @(posedge clock);
        #1;
        if (bus.wb_valid) mpend[bus.wb_dr] = 1'b0;
        if (bus.flush && m.valid && m.wr) mpend[m.dr] = 1'b0;
        if (acc && bus.in_wr) mpend[bus.in_dr] = 1'b1;
        if (bus.flush)
            m.valid = 1'b0;
        else if (acc)
            m = '{1'b1, d1, d2, bus.in_dr, bus.in_wr, bus.in_npc, bus.in_ir};
        else if (bus.out_ready)
            m.valid = 1'b0;
        if (bus.wb_valid) rf[bus.wb_dr] = bus.wb_data;
        last_acc = acc;
        if (acc) acc_count++;
        chk("out_valid", bus.out_valid, m.valid);
        chk("pend", dut.u_sb.pend, pend_vec());
        if (m.valid) begin
            chk("out_vsr1", bus.out_vsr1, m.v1);
            chk("out_vsr2", bus.out_vsr2, m.v2);
            chk("out_dr", bus.out_dr, m.dr);
            chk("out_wr", bus.out_wr, m.wr);
            chk("out_npc", bus.out_npc, m.npc);
            chk("out_ir", bus.out_ir, m.ir);
        end
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 1'b0);
        chk({tag, "_pend"}, dut.u_sb.pend, 8'h00);
        chk({tag, "_vsr1"}, bus.out_vsr1, 16'h0000);
        chk({tag, "_vsr2"}, bus.out_vsr2, 16'h0000);
        chk({tag, "_dr_wr"}, {bus.out_dr, bus.out_wr}, 4'h0);
        chk({tag, "_npc"}, bus.out_npc, 16'h0000);
        chk({tag, "_ir"}, bus.out_ir, 16'h0000);
    endtask

    initial begin
        logic [15:0] saved_ir, saved_v1, saved_npc;
        int          base_acc, base_out;
        logic [2:0]  cand [$];

        for (int i = 0; i < 8; i++) rf[i] = 16'($urandom);
        model_reset();
        acc_count = 0; out_count = 0; track_npc = 1'b0; last_acc = 1'b0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        set_wb(1'b0, 3'd0, 16'h0);

        // Reset held low with a valid offer: nothing may be captured.
        set_instr(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 16'h3001, 16'h1283);
        #23;
        check_cleared("reset");
        set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("ready_after_reset", bus.in_ready, 1'b1);

        // ADD R1 <- R2 + R3
        set_instr(1'b1, 3'd2, 1'b1, 3'd3, 1'b1, 3'd1, 1'b1, 16'h3001, 16'h1283);
        tick();
        chk("add_valid", bus.out_valid, 1'b1);
        chk("add_pend1", dut.u_sb.pend[1], 1'b1);

        // RAW on R1, then R1 retires with 00A5
        set_instr(1'b1, 3'd1, 1'b1, 3'd0, 1'b0, 3'd2, 1'b0, 16'h3002, 16'h5460);
        tick();
        chk("raw_stall", last_acc, 1'b0);
        set_wb(1'b1, 3'd1, 16'h00A5);
        tick();
        chk("raw_retire_acc", last_acc, BYP);
        set_wb(1'b0, 3'd0, 16'h0);
        if (!last_acc) begin
            tick();
            chk("raw_late_acc", last_acc, 1'b1);
        end
        chk("raw_vsr1", bus.out_vsr1, 16'h00A5);

        // Execute stalls for three cycles; then back-to-back handoff
        bus.out_ready = 1'b0;
        saved_ir = bus.out_ir; saved_v1 = bus.out_vsr1; saved_npc = bus.out_npc;
        set_instr(1'b1, 3'd4, 1'b1, 3'd5, 1'b1, 3'd6, 1'b0, 16'h3003, 16'h1D05);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_noacc", last_acc, 1'b0);
            chk("hold_ir", bus.out_ir, saved_ir);
            chk("hold_vsr1", bus.out_vsr1, saved_v1);
            chk("hold_npc", bus.out_npc, saved_npc);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("b2b_acc", last_acc, 1'b1);
        chk("b2b_ir", bus.out_ir, 16'h1D05);

        // WAW on R3
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 16'h3004, 16'h2600);
        tick();
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd3, 1'b1, 16'h3005, 16'hBEEF);
        tick();
        chk("waw_stall1", last_acc, 1'b0);
        tick();
        chk("waw_stall2", last_acc, 1'b0);
        set_wb(1'b1, 3'd3, 16'h1234);
        tick();
        chk("waw_retire_acc", last_acc, BYP);
        set_wb(1'b0, 3'd0, 16'h0);
        if (!last_acc) begin
            tick();
            chk("waw_late_acc", last_acc, 1'b1);
        end
        chk("waw_pend3", dut.u_sb.pend[3], 1'b1);
        chk("waw_ir", bus.out_ir, 16'hBEEF);

        // Flush kills an R5 writer; the offer in the flush cycle is refused
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd5, 1'b1, 16'h3006, 16'h2A00);
        tick();
        chk("flush_setup_pend5", dut.u_sb.pend[5], 1'b1);
        bus.out_ready = 1'b0;
        bus.flush = 1'b1;
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd7, 1'b0, 16'h3007, 16'h1111);
        tick();
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        chk("flush_noacc", last_acc, 1'b0);
        chk("flush_valid", bus.out_valid, 1'b0);
        chk("flush_pend5", dut.u_sb.pend[5], 1'b0);

        // 20 independent instructions streamed at full rate
        mpend[3] = mpend[3];
        set_wb(1'b1, 3'd3, 16'h0F0F);
        set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        tick();
        set_wb(1'b0, 3'd0, 16'h0);
        track_npc = 1'b1;
        base_acc = acc_count; base_out = out_count;
        for (int i = 0; i < 20; i++) begin
            set_instr(1'b1, 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                      3'($urandom), 1'b0, 16'h3100 + 16'(i), 16'($urandom));
            npcq.push_back(16'h3100 + 16'(i));
            tick();
        end
        set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        tick();
        track_npc = 1'b0;
        chk("stream_accepts", acc_count - base_acc, 20);
        chk("stream_outputs", out_count - base_out, 20);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            cand.delete();
            for (int i = 0; i < 8; i++) if (mpend[i]) cand.push_back(3'(i));
            if ($urandom_range(0, 1) == 1)
                set_wb(1'b1, (cand.size() > 0 && $urandom_range(0, 3) != 0) ?
                       cand[$urandom_range(0, cand.size() - 1)] : 3'($urandom), 16'($urandom));
            else
                set_wb(1'b0, 3'($urandom), 16'($urandom));
            bus.flush     = ($urandom_range(0, 19) == 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            set_instr(1'($urandom), 3'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                      3'($urandom), 1'($urandom), 16'($urandom), 16'($urandom));
            tick();
        end
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        set_wb(1'b0, 3'd0, 16'h0);

        // Reset asserted mid-stall drops the entry and all pending bits
        for (int i = 0; i < 8; i++) begin
            set_wb(1'b1, 3'(i), 16'($urandom));
            set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
            tick();
        end
        set_wb(1'b0, 3'd0, 16'h0);
        set_instr(1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 3'd6, 1'b1, 16'h3200, 16'h2C00);
        tick();
        bus.out_ready = 1'b0;
        set_instr(1'b1, 3'd6, 1'b1, 3'd0, 1'b0, 3'd1, 1'b0, 16'h3201, 16'h1380);
        tick();
        chk("pre_reset_stall", last_acc, 1'b0);
        reset = 1'b0;
        #2;
        model_reset();
        check_cleared("midreset");
        set_instr(1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 16'h0, 16'h0);
        bus.out_ready = 1'b1;
        #2;
        reset = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Register-read stage of the LC-3 pipeline, sitting between decode and execute. It is the read-side counterpart of writeback. It drives the register-file read addresses and captures the two source operands into an output pipeline register. A per-register scoreboard of in-flight writes stalls decode on read-after-write (RAW) and write-after-write (WAW) hazards until writeback retires the pending write.

## Interface
Parameters:
- DW, 16, data width
- NREG, 8, number of architectural registers (address width fixed at 3)

Ports:
- clock  in  1  single clock; all state updates on posedge
- reset  in  1  asynchronous, active-low; all state clears while low
- flush  in  1  kills the entry held in the output register
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  stage accepts it this cycle
- in_sr1, in_sr2, in_dr  in  3 each  source and destination register numbers
- in_use1, in_use2, in_wr  in  1 each  sr1 read, sr2 read, dr written
- in_npc  in  16  next PC, carried through
- in_ir  in  16  instruction word, carried through
- rf_sr1, rf_sr2  out  3 each  register-file read addresses; equal to in_sr1 and in_sr2
- rf_d1, rf_d2  in  DW each  register-file read data (combinational)
- wb_valid  in  1  writeback writes the register file this cycle
- wb_dr  in  3  writeback destination register
- wb_data  in  DW  writeback data
- out_valid  out  1  output register holds an instruction
- out_ready  in  1  execute consumes it
- out_vsr1, out_vsr2  out  DW each  operand values
- out_dr  out  3  destination register, carried through
- out_wr  out  1  dr-written flag, carried through
- out_npc  out  16  carried through
- out_ir  out  16  carried through

## Operation
- Scoreboard: pend[NREG], one bit per register; bit set means a write is in flight.
- Output register has two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
  - EMPTY→FULL on accept.
  - FULL→EMPTY on out_ready with no accept.
  - FULL→FULL on out_ready with an accept (back-to-back).
  - FULL with !out_ready holds the entry and all its fields.
- Bypass hit for a source s: wb_valid && wb_dr==s && pend[s].
- Hazard:
  - RAW: (in_use1 && pend[in_sr1] && !hit1), or the same term for sr2.
  - WAW: in_wr && pend[in_dr] && !(wb_valid && wb_dr==in_dr).
- in_ready = !hazard && !flush && (!out_valid || out_ready). in_ready is combinational; it does not depend on in_valid.
- Accept = in_valid && in_ready. On accept the output register captures:
  - the operands, each either rf_d or wb_data on a bypass hit,
  - in_dr, in_wr, in_npc, in_ir.
- Scoreboard update order within a cycle: clear on wb_valid (pend[wb_dr]=0) first, then set on accept with in_wr (pend[in_dr]=1). When both target the same register, the result is pend=1.
- Unused source fields never stall.
- wb_valid with pend[wb_dr]=0 is legal; it only updates the register file.
- flush:
  - Output register → EMPTY.
  - If the killed entry had out_wr=1, pend[out_dr] is cleared.
  - No accept occurs in a flush cycle.
  - wb_valid clears still apply in a flush cycle.

## Timing
- Reset (reset low):
  - pend=0, out_valid=0.
  - out_vsr1, out_vsr2, out_dr, out_wr, out_npc, out_ir all 0.
  - in_ready follows its equation, which gives 1 after reset.
- Latency: accept in cycle N → out_valid and data visible in cycle N+1.
- Without bypass, a RAW on a register retiring in cycle N is accepted in cycle N+1, and reads the register-file value written at the N edge.
- Full throughput is one instruction per cycle when there are no hazards and out_ready=1.
- Reset asserted mid-stall drops the held entry and all pending bits with no output handshake.

## Configuration
- BYPASS_EN defined:
  - wb_data forwards into the operand capture, and the RAW stall is removed in the retire cycle.
  - Same-cycle clear and set on one register is permitted for WAW.
- BYPASS_EN undefined:
  - hit1 and hit2 are forced to 0, and the WAW exemption is removed.
  - The stage stalls through the retire cycle. Scoreboard ordering is unchanged.

## Structure
- Shared package/include holds DW, NREG, the register-address width, and the EMPTY/FULL state encodings.
- The scoreboard (set, clear, flush-clear, hazard lookup) is one natural sub-module: operand_scoreboard.
- The output register and handshake stay in the top level.

## Test plan
- Reset low with in_valid=1 → out_valid=0, in_ready=1 once reset is released, pend=0. Release, then issue ADD R1 (in_wr=1, dr=1) → out_valid next cycle, pend[1]=1.
- With pend[1]=1, issue a read of sr1=1 → in_ready=0. Then wb_valid=1, wb_dr=1, wb_data=16'h00A5:
  - With BYPASS_EN: accepted in that cycle, out_vsr1=16'h00A5.
  - Without BYPASS_EN: accepted one cycle later, out_vsr1=16'h00A5 read from the register file.
- Hold out_ready=0 for 3 cycles while FULL → in_ready=0 and all out fields stable. Then out_ready=1 with a new valid instruction → back-to-back handoff and no bubble.
- With pend[3]=1, issue an instruction with in_wr=1, dr=3 and no sr use → WAW stall until wb_dr=3 retires. Then pend[3]=1 again, owned by the new instruction.
- Entry in output with out_wr=1, dr=5, then flush=1 → next cycle out_valid=0 and pend[5]=0. An in_valid in the flush cycle is not accepted.
- Stream 20 independent instructions with out_ready=1 → 20 outputs in 20 consecutive cycles, in_npc/in_ir order preserved, operands matching a reference register model.
